// File: rtl/otp_auth_core_if.sv
// Handshake and status bundle for the OTP authenticator core.
// The master side keys digits and starts sessions; the slave side reports results.
interface otp_auth_core_if #(
  parameter int DIGITS = 4
);
  logic                  otp_latch;
  logic                  user_latch;
  logic [3:0]            user_in;
  logic [DIGITS*4-1:0]   otp_value;
  logic                  busy;
  logic                  pass;
  logic                  fail;
  logic                  locked;

  modport master (
    output otp_latch, user_latch, user_in,
    input  otp_value, busy, pass, fail, locked
  );

  modport slave (
    input  otp_latch, user_latch, user_in,
    output otp_value, busy, pass, fail, locked
  );
endinterface

// File: rtl/otp_auth_core.sv
// OTP authenticator: LFSR-sourced one-time password, digit entry with timeout,
// retry counting with lockout, and two scanned active-low seven-segment buses.
module otp_auth_core #(
  parameter int          DIGITS    = 4,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 3,
  parameter int          TIMEOUT   = 1000,
  parameter int          SCAN_DIV  = 50000
) (
  input  logic              clk,
  input  logic              reset,
  otp_auth_core_if.slave    bus,
  output logic [6:0]        otp_seg,
  output logic [6:0]        user_seg,
  output logic [DIGITS-1:0] an
);

  localparam int NW  = DIGITS * 4;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int TW  = $clog2(TIMEOUT);
  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  state_t            state_r, state_s;
  logic [15:0]       lfsr_r, lfsr_s;
  logic [NW-1:0]     otp_r, otp_s;
  logic [NW-1:0]     entry_r, entry_s;
  logic [DIGITS-1:0] written_r, written_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [TRW-1:0]    tries_r, tries_s, tries_inc_s;
  logic [TW-1:0]     timer_r, timer_s;
  logic [SW-1:0]     scan_r, scan_s;
  logic [IW-1:0]     index_r, index_s;
  logic [IW-1:0]     slot_s;
  logic              start_s, match_s;
  logic              pass_r, pass_s, fail_r, fail_s;
  logic              busy_r, busy_s, locked_r, locked_s;
  logic [6:0]        otp_seg_r, otp_seg_s, user_seg_r, user_seg_s;
  logic [DIGITS-1:0] an_r, an_s;

  // Session FSM next state: capture, digit entry, timeout and verdict.
  always_comb begin
    state_s     = state_r;
    otp_s       = otp_r;
    entry_s     = entry_r;
    written_s   = written_r;
    cnt_s       = cnt_r;
    tries_s     = tries_r;
    timer_s     = timer_r;
    pass_s      = 1'b0;
    fail_s      = 1'b0;
    lfsr_s      = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[14] ^ lfsr_r[12] ^ lfsr_r[3]};
    start_s     = bus.otp_latch && ((state_r == ST_IDLE) || (state_r == ST_ENTRY));
    slot_s      = IW'(DIGITS - 1) - IW'(cnt_r);
    match_s     = (cnt_r == CW'(DIGITS)) && (entry_r == otp_r);
    tries_inc_s = tries_r + TRW'(1);

    if (start_s) begin
      // A restart wins over a coincident digit latch.
      otp_s     = lfsr_r[NW-1:0];
      entry_s   = {NW{1'b0}};
      written_s = {DIGITS{1'b0}};
      cnt_s     = {CW{1'b0}};
      timer_s   = {TW{1'b0}};
      state_s   = ST_ENTRY;
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_IDLE;
        ST_ENTRY: begin
          if (bus.user_latch) begin
            entry_s[{slot_s, 2'b00} +: 4] = bus.user_in;
            written_s[slot_s]             = 1'b1;
            cnt_s                         = cnt_r + CW'(1);
            timer_s                       = {TW{1'b0}};
            if (cnt_r == CW'(DIGITS - 1)) begin
              state_s = ST_CHECK;
            end else begin
              state_s = ST_ENTRY;
            end
          end else if (timer_r == TW'(TIMEOUT - 1)) begin
            // Short entry never matches, so CHECK reports the timeout as a fail.
            state_s = ST_CHECK;
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
        ST_CHECK: begin
          if (match_s) begin
            pass_s  = 1'b1;
            tries_s = {TRW{1'b0}};
            state_s = ST_IDLE;
          end else begin
            fail_s  = 1'b1;
            tries_s = tries_inc_s;
            if (tries_inc_s == TRW'(MAX_TRIES)) begin
              state_s = ST_LOCKED;
            end else begin
              state_s = ST_IDLE;
            end
          end
        end
        ST_LOCKED: state_s = ST_LOCKED;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // Display scan and segment decode, aligned with the next registered state.
  always_comb begin
    if (scan_r == SW'(SCAN_DIV - 1)) begin
      scan_s = {SW{1'b0}};
      if (index_r == IW'(DIGITS - 1)) begin
        index_s = {IW{1'b0}};
      end else begin
        index_s = index_r + IW'(1);
      end
    end else begin
      scan_s  = scan_r + SW'(1);
      index_s = index_r;
    end
    busy_s   = (state_s == ST_ENTRY) || (state_s == ST_CHECK);
    locked_s = (state_s == ST_LOCKED);
    an_s     = ~(DIGITS'(1) << index_s);
    if (busy_s) begin
      otp_seg_s = hex_seg(otp_s[{index_s, 2'b00} +: 4]);
    end else begin
      otp_seg_s = 7'h7F;
    end
    if (written_s[index_s]) begin
      user_seg_s = hex_seg(entry_s[{index_s, 2'b00} +: 4]);
    end else begin
      user_seg_s = 7'h7F;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      lfsr_r     <= SEED;
      otp_r      <= {NW{1'b0}};
      entry_r    <= {NW{1'b0}};
      written_r  <= {DIGITS{1'b0}};
      cnt_r      <= {CW{1'b0}};
      tries_r    <= {TRW{1'b0}};
      timer_r    <= {TW{1'b0}};
      scan_r     <= {SW{1'b0}};
      index_r    <= {IW{1'b0}};
      pass_r     <= 1'b0;
      fail_r     <= 1'b0;
      busy_r     <= 1'b0;
      locked_r   <= 1'b0;
      otp_seg_r  <= 7'h7F;
      user_seg_r <= 7'h7F;
      an_r       <= ~DIGITS'(1);
    end else begin
      state_r    <= state_s;
      lfsr_r     <= lfsr_s;
      otp_r      <= otp_s;
      entry_r    <= entry_s;
      written_r  <= written_s;
      cnt_r      <= cnt_s;
      tries_r    <= tries_s;
      timer_r    <= timer_s;
      scan_r     <= scan_s;
      index_r    <= index_s;
      pass_r     <= pass_s;
      fail_r     <= fail_s;
      busy_r     <= busy_s;
      locked_r   <= locked_s;
      otp_seg_r  <= otp_seg_s;
      user_seg_r <= user_seg_s;
      an_r       <= an_s;
    end
  end

  assign bus.otp_value = otp_r;
  assign bus.busy      = busy_r;
  assign bus.pass      = pass_r;
  assign bus.fail      = fail_r;
  assign bus.locked    = locked_r;
  assign otp_seg       = otp_seg_r;
  assign user_seg      = user_seg_r;
  assign an            = an_r;

endmodule
